hex_scan_ctrl: RTL and testbench
================================

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, giving clock cycles per digit slot (legal range 2..65535).
REQ-002 The block SHALL have port clk_i  input  1  system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port we_i  input  1  write strobe; samples data_i and mask_i into the shadow registers.
REQ-005 The block SHALL have port data_i  input  32  eight hex nibbles; nibble k = data_i[4k+3:4k] drives digit k.
REQ-006 The block SHALL have port mask_i  input  8  per-digit enable; bit k = 1 shows digit k.
REQ-007 The block SHALL have port an_o  output  8  digit anodes, active-low, one-hot-low or all-high.
REQ-008 The block SHALL have port seg_o  output  7  segments, active-low, bit0 = a ... bit6 = g.
REQ-009 The block SHALL have port pending_o  output  1  shadow holds a write not yet applied.
REQ-010 The block SHALL have port frame_o  output  1  one-cycle pulse at each frame boundary.

Function
REQ-011 The block SHALL hold a prescaler cnt counting 0..DIV-1 and wrapping to 0; tick = (cnt == DIV-1).
REQ-012 The block SHALL hold a digit index idx (3 bits), incremented modulo 8 on the cycle after tick is high.
REQ-013 A frame boundary SHALL be tick high while idx == 7; one frame = 8*DIV cycles.
REQ-014 On we_i high, shadow data/mask SHALL load data_i/mask_i and pending_o SHALL be 1 from the next cycle; back-to-back writes: last write wins.
REQ-015 On a frame boundary with pending_o = 1, active data/mask SHALL load the shadow, pending_o SHALL clear, and the new values SHALL be displayed from idx = 0 onward (no mid-frame tearing).
REQ-016 frame_o SHALL be 1 during the cycle after every frame boundary, regardless of pending_o.
REQ-017 we_i coinciding with a frame boundary SHALL apply the previous shadow contents, write the new values to shadow, and leave pending_o = 1.
REQ-018 an_o and seg_o SHALL be combinational from idx and the active registers, with no added latency.
REQ-019 A shown digit SHALL drive an_o = ~(8'b1 << idx) and seg_o by hex pattern: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,B=03,C=46,D=21,E=06,F=0E (hex).
REQ-020 A blanked digit SHALL drive an_o = 8'hFF and seg_o = 7'h7F.

Reset
REQ-021 While rst_i is high: cnt = 0, idx = 0, active and shadow data = 0, active and shadow mask = 8'h00, pending_o = 0, frame_o = 0, an_o = 8'hFF, seg_o = 7'h7F.
REQ-022 Reset asserted mid-frame or with a write pending SHALL discard the pending write; scanning restarts at idx = 0, cnt = 0 after release.

Configuration
REQ-023 With macro HEX_SCAN_LZB_EN defined, digit k > 0 SHALL also be blanked when active nibbles k..7 are all zero (leading-zero blanking); digit 0 follows mask only.
REQ-024 Without HEX_SCAN_LZB_EN, blanking SHALL depend on the active mask only.

Verification
REQ-025 DIV=4, reset release, no writes -> an_o = 8'hFF, seg_o = 7'h7F for 64 cycles; frame_o pulses every 32 cycles.
REQ-026 DIV=4, write data 32'h76543210, mask 8'hFF -> pending_o = 1 until the next boundary; next frame shows idx 0..7 with seg_o 40,79,24,30,19,12,02,78, each for 4 cycles, an_o FE..7F.
REQ-027 DIV=4, write mask 8'h05 -> in the applied frame only idx 0 and 2 drive anodes; other slots give an_o = FF, seg_o = 7F.
REQ-028 DIV=4, we_i asserted exactly at the boundary cycle with data 32'hFFFFFFFF after an earlier pending write of 32'h0 -> next frame shows 0s, pending_o stays 1, following frame shows F (0E).
REQ-029 rst_i pulsed during idx = 5 with a write pending -> outputs blank immediately (asynchronous), pending_o = 0, old shadow never displayed.
REQ-030 HEX_SCAN_LZB_EN defined, data 32'h000000A0, mask 8'hFF -> digits 0,1 show 40 and 08; digits 2..7 blanked.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: eight-digit multiplexed hex display scanner.
// Writes land in a shadow register and are promoted to the displayed (active) registers only at
// a frame boundary, so a frame never shows a mix of old and new contents.
// Optional feature: define HEX_SCAN_LZB_EN to enable leading-zero blanking.
module hex_scan_ctrl #(
  parameter int unsigned DIV = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  mask_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        pending_o,
  output logic        frame_o
);

  localparam logic [15:0] CntMax = 16'(DIV - 1);

  // Prescaler and scan position
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        tick;
  logic        boundary;

  // Double-buffered display contents
  logic [31:0] shadow_data_q, shadow_data_d;
  logic [7:0]  shadow_mask_q, shadow_mask_d;
  logic [31:0] active_data_q, active_data_d;
  logic [7:0]  active_mask_q, active_mask_d;
  logic        pending_q, pending_d;
  logic        frame_q, frame_d;

  // Digit decode
  logic [31:0] shifted_data;
  logic [3:0]  nibble;
  logic [6:0]  hex_seg;
  logic        shown;

  assign tick     = (cnt_q == CntMax);
  assign boundary = tick && (idx_q == 3'd7);

  // Prescaler wraps at DIV-1; the digit index advances on each tick.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    idx_d = idx_q;
    if (tick) begin
      cnt_d = 16'd0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Shadow capture, promotion at the frame boundary and frame pulse.
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_mask_d = shadow_mask_q;
    active_data_d = active_data_q;
    active_mask_d = active_mask_q;
    pending_d     = pending_q;
    frame_d       = boundary;

    // Promotion uses the pre-write shadow, so a write on the boundary cycle stays pending.
    if (boundary && pending_q) begin
      active_data_d = shadow_data_q;
      active_mask_d = shadow_mask_q;
      pending_d     = 1'b0;
    end

    if (we_i) begin
      shadow_data_d = data_i;
      shadow_mask_d = mask_i;
      pending_d     = 1'b1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q         <= 16'd0;
      idx_q         <= 3'd0;
      shadow_data_q <= 32'd0;
      shadow_mask_q <= 8'h00;
      active_data_q <= 32'd0;
      active_mask_q <= 8'h00;
      pending_q     <= 1'b0;
      frame_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_mask_q <= shadow_mask_d;
      active_data_q <= active_data_d;
      active_mask_q <= active_mask_d;
      pending_q     <= pending_d;
      frame_q       <= frame_d;
    end
  end

  assign pending_o = pending_q;
  assign frame_o   = frame_q;

  // Select the nibble for the digit currently being scanned.
  assign shifted_data = active_data_q >> {idx_q, 2'b00};
  assign nibble       = shifted_data[3:0];

  // Hex to active-low seven-segment pattern, bit0 = a ... bit6 = g.
  always_comb begin
    hex_seg = 7'h7F;
    case (nibble)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      4'hF: hex_seg = 7'h0E;
      default: hex_seg = 7'h7F;
    endcase
  end

`ifdef HEX_SCAN_LZB_EN
  // upper_nz[k] is set when any active nibble k..7 is non-zero.
  logic [7:0] upper_nz;

  // Leading-zero detection, accumulated from the most significant nibble down.
  always_comb begin
    upper_nz    = 8'h00;
    upper_nz[7] = |active_data_q[31:28];
    for (int k = 6; k >= 0; k--) begin
      upper_nz[k] = upper_nz[k+1] | (|active_data_q[4*k +: 4]);
    end
  end

  // Digit 0 always follows the mask so a zero value still shows a single 0.
  assign shown = active_mask_q[idx_q] && ((idx_q == 3'd0) || upper_nz[idx_q]);
`else
  assign shown = active_mask_q[idx_q];
`endif

  // Drive the selected anode low and its segments, or blank everything.
  always_comb begin
    an_o  = 8'hFF;
    seg_o = 7'h7F;
    if (shown) begin
      an_o  = ~(8'b1 << idx_q);
      seg_o = hex_seg;
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: directed self-checking bench for hex_scan_ctrl with DIV = 4
// (one digit slot = 4 cycles, one frame = 32 cycles).
module tb_hex_scan_ctrl;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [31:0] data = 32'd0;
  logic [7:0]  mask = 8'h00;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        pending;
  logic        frame;

  int checks = 0;
  int fails = 0;
  int cyc = 0;  // cycles since the last reset release

  always #5 clk = ~clk;

  hex_scan_ctrl #(.DIV(DIV)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (we),
    .data_i   (data),
    .mask_i   (mask),
    .an_o     (an),
    .seg_o    (seg),
    .pending_o(pending),
    .frame_o  (frame)
  );

  // Segment table for a hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'h40; 4'h1: r = 7'h79; 4'h2: r = 7'h24; 4'h3: r = 7'h30;
      4'h4: r = 7'h19; 4'h5: r = 7'h12; 4'h6: r = 7'h02; 4'h7: r = 7'h78;
      4'h8: r = 7'h00; 4'h9: r = 7'h10; 4'hA: r = 7'h08; 4'hB: r = 7'h03;
      4'hC: r = 7'h46; 4'hD: r = 7'h21; 4'hE: r = 7'h06; default: r = 7'h0E;
    endcase
    return r;
  endfunction

  function automatic logic is_shown(input int k, input logic [31:0] d, input logic [7:0] m);
    logic s;
    s = m[k];
`ifdef HEX_SCAN_LZB_EN
    if (k > 0 && (d >> (4 * k)) == 32'd0) s = 1'b0;
`endif
    return s;
  endfunction

  function automatic logic [7:0] exp_an(input int k, input logic [31:0] d, input logic [7:0] m);
    return is_shown(k, d, m) ? ~(8'b1 << k) : 8'hFF;
  endfunction

  function automatic logic [6:0] exp_seg(input int k, input logic [31:0] d, input logic [7:0] m);
    logic [31:0] sh;
    sh = d >> (4 * k);
    return is_shown(k, d, m) ? hex7(sh[3:0]) : 7'h7F;
  endfunction

  // Sampling and driving both happen at the falling edge.
  task automatic next();
    @(negedge clk);
    cyc = cyc + 1;
  endtask

  task automatic write(input logic [31:0] d, input logic [7:0] m);
    we = 1'b1; data = d; mask = m;
    next();
    we = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (an !== 8'hFF) begin fails++; $display("FAIL reset_an got %h want ff", an); end
    checks++; if (seg !== 7'h7F) begin fails++; $display("FAIL reset_seg got %h want 7f", seg); end
    checks++; if (pending !== 1'b0) begin fails++; $display("FAIL reset_pend got %b want 0", pending); end
    checks++; if (frame !== 1'b0) begin fails++; $display("FAIL reset_frame got %b want 0", frame); end
    // Writes while in reset must be ignored.
    we = 1'b1; data = 32'hFFFF_FFFF; mask = 8'hFF;
    repeat (3) @(negedge clk);
    checks++; if (pending !== 1'b0) begin fails++; $display("FAIL reset_we_pend got %b want 0", pending); end
    checks++; if (an !== 8'hFF) begin fails++; $display("FAIL reset_we_an got %h want ff", an); end
    we = 1'b0;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_idle();
    while (cyc < 64) begin
      checks++; if (an !== 8'hFF) begin fails++; $display("FAIL idle_an cyc=%0d got %h want ff", cyc, an); end
      checks++; if (seg !== 7'h7F) begin fails++; $display("FAIL idle_seg cyc=%0d got %h want 7f", cyc, seg); end
      checks++;
      if (frame !== (cyc == 32)) begin
        fails++; $display("FAIL idle_frame cyc=%0d got %b want %b", cyc, frame, cyc == 32);
      end
      next();
    end
  endtask

  task automatic test_write();
    checks++; if (pending !== 1'b0) begin fails++; $display("FAIL wr_pend0 got %b want 0", pending); end
    write(32'h7654_3210, 8'hFF);
    while (cyc < 96) begin
      checks++; if (pending !== 1'b1) begin fails++; $display("FAIL wr_pend1 cyc=%0d got %b want 1", cyc, pending); end
      checks++; if (an !== 8'hFF) begin fails++; $display("FAIL wr_old_an cyc=%0d got %h want ff", cyc, an); end
      next();
    end
    while (cyc < 128) begin
      checks++;
      if (an !== ~(8'b1 << ((cyc / 4) % 8))) begin
        fails++; $display("FAIL wr_an cyc=%0d got %h want %h", cyc, an, ~(8'b1 << ((cyc / 4) % 8)));
      end
      checks++;
      if (seg !== exp_seg((cyc / 4) % 8, 32'h7654_3210, 8'hFF)) begin
        fails++;
        $display("FAIL wr_seg cyc=%0d got %h want %h", cyc, seg,
                 exp_seg((cyc / 4) % 8, 32'h7654_3210, 8'hFF));
      end
      checks++; if (pending !== 1'b0) begin fails++; $display("FAIL wr_pend2 cyc=%0d got %b want 0", cyc, pending); end
      checks++;
      if (frame !== (cyc == 96)) begin fails++; $display("FAIL wr_frame cyc=%0d got %b want %b", cyc, frame, cyc == 96); end
      next();
    end
    // Hand-computed spot checks of the applied frame.
    checks++; if (hex7(4'h5) !== 7'h12) begin fails++; $display("FAIL tbl_5 got %h want 12", hex7(4'h5)); end
  endtask

  task automatic test_mask();
    next(); next();
    write(32'h7654_3210, 8'h05);
    while (cyc < 160) next();
    while (cyc < 192) begin
      checks++;
      if (an !== exp_an((cyc / 4) % 8, 32'h7654_3210, 8'h05)) begin
        fails++;
        $display("FAIL mask_an cyc=%0d got %h want %h", cyc, an, exp_an((cyc / 4) % 8, 32'h7654_3210, 8'h05));
      end
      checks++;
      if (seg !== exp_seg((cyc / 4) % 8, 32'h7654_3210, 8'h05)) begin
        fails++;
        $display("FAIL mask_seg cyc=%0d got %h want %h", cyc, seg, exp_seg((cyc / 4) % 8, 32'h7654_3210, 8'h05));
      end
      if (cyc == 169) begin
        checks++;
        if (an !== 8'hFB || seg !== 7'h24) begin
          fails++; $display("FAIL mask_idx2 got %h/%h want fb/24", an, seg);
        end
      end
      next();
    end
  endtask

  task automatic test_back_to_back();
    while (cyc < 200) next();
    write(32'h0000_0000, 8'hFF);
    while (cyc < 223) next();
    // Boundary cycle: previous shadow (zeros) is applied, new value stays pending.
    write(32'hFFFF_FFFF, 8'hFF);
    while (cyc < 256) begin
      checks++; if (pending !== 1'b1) begin fails++; $display("FAIL b2b_pend cyc=%0d got %b want 1", cyc, pending); end
      checks++;
      if (an !== exp_an((cyc / 4) % 8, 32'd0, 8'hFF) || seg !== exp_seg((cyc / 4) % 8, 32'd0, 8'hFF)) begin
        fails++;
        $display("FAIL b2b_zero cyc=%0d got %h/%h want %h/%h", cyc, an, seg,
                 exp_an((cyc / 4) % 8, 32'd0, 8'hFF), exp_seg((cyc / 4) % 8, 32'd0, 8'hFF));
      end
      next();
    end
    while (cyc < 288) begin
      checks++; if (pending !== 1'b0) begin fails++; $display("FAIL b2b_pend2 cyc=%0d got %b want 0", cyc, pending); end
      checks++;
      if (an !== ~(8'b1 << ((cyc / 4) % 8)) || seg !== 7'h0E) begin
        fails++; $display("FAIL b2b_f cyc=%0d got %h/%h want %h/0e", cyc, an, seg, ~(8'b1 << ((cyc / 4) % 8)));
      end
      next();
    end
  endtask

  task automatic test_reset_mid();
    write(32'h1111_1111, 8'hFF);
    while (cyc < 308) next();
    checks++;
    if (an !== 8'hDF || seg !== 7'h0E || pending !== 1'b1) begin
      fails++; $display("FAIL rmid_pre got %h/%h/%b want df/0e/1", an, seg, pending);
    end
    // Assert reset between clock edges; outputs must blank without a clock.
    #2 rst = 1'b1;
    #1;
    checks++; if (an !== 8'hFF) begin fails++; $display("FAIL rmid_an got %h want ff", an); end
    checks++; if (seg !== 7'h7F) begin fails++; $display("FAIL rmid_seg got %h want 7f", seg); end
    checks++; if (pending !== 1'b0) begin fails++; $display("FAIL rmid_pend got %b want 0", pending); end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      checks++;
      if (an !== 8'hFF || seg !== 7'h7F || pending !== 1'b0) begin
        fails++; $display("FAIL rmid_post cyc=%0d got %h/%h/%b want ff/7f/0", cyc, an, seg, pending);
      end
      checks++;
      if (frame !== (cyc == 32)) begin fails++; $display("FAIL rmid_frame cyc=%0d got %b want %b", cyc, frame, cyc == 32); end
      next();
    end
  endtask

  task automatic test_lzb();
    write(32'h0000_00A0, 8'hFF);
    while (cyc < 64) next();
    while (cyc < 96) begin
      checks++;
      if (an !== exp_an((cyc / 4) % 8, 32'h0000_00A0, 8'hFF)) begin
        fails++;
        $display("FAIL lzb_an cyc=%0d got %h want %h", cyc, an, exp_an((cyc / 4) % 8, 32'h0000_00A0, 8'hFF));
      end
      checks++;
      if (seg !== exp_seg((cyc / 4) % 8, 32'h0000_00A0, 8'hFF)) begin
        fails++;
        $display("FAIL lzb_seg cyc=%0d got %h want %h", cyc, seg, exp_seg((cyc / 4) % 8, 32'h0000_00A0, 8'hFF));
      end
      if (cyc == 65) begin
        checks++; if (seg !== 7'h40) begin fails++; $display("FAIL lzb_d0 got %h want 40", seg); end
      end
      if (cyc == 69) begin
        checks++; if (seg !== 7'h08) begin fails++; $display("FAIL lzb_d1 got %h want 08", seg); end
      end
      next();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_write();
    test_mask();
    test_back_to_back();
    test_reset_mid();
    test_lzb();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
